// File: rtl/alu_pkg.sv
// Shared constants for the ALU control decoder and multiply/divide unit.
package alu_pkg;

    // 4-bit ALU control codes presented on alu_ctrl
    localparam logic [3:0] CtrlAnd     = 4'b0000;
    localparam logic [3:0] CtrlOr      = 4'b0001;
    localparam logic [3:0] CtrlAdd     = 4'b0010;
    localparam logic [3:0] CtrlSub     = 4'b0110;
    localparam logic [3:0] CtrlSlt     = 4'b0111;
    localparam logic [3:0] CtrlMult    = 4'b1000;
    localparam logic [3:0] CtrlMultu   = 4'b1001;
    localparam logic [3:0] CtrlDiv     = 4'b1010;
    localparam logic [3:0] CtrlDivu    = 4'b1011;
    localparam logic [3:0] CtrlNor     = 4'b1100;
    localparam logic [3:0] CtrlMfhi    = 4'b1101;
    localparam logic [3:0] CtrlMflo    = 4'b1110;
    localparam logic [3:0] CtrlIllegal = 4'b1111;

    // Main-control alu_op encodings
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;
    localparam logic [1:0] AluOpOr    = 2'b11;

    // R-type funct encodings
    localparam logic [5:0] FnAdd   = 6'b100000;
    localparam logic [5:0] FnAddu  = 6'b100001;
    localparam logic [5:0] FnSub   = 6'b100010;
    localparam logic [5:0] FnSubu  = 6'b100011;
    localparam logic [5:0] FnAnd   = 6'b100100;
    localparam logic [5:0] FnOr    = 6'b100101;
    localparam logic [5:0] FnNor   = 6'b100111;
    localparam logic [5:0] FnSlt   = 6'b101010;
    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;
    localparam logic [5:0] FnMfhi  = 6'b010000;
    localparam logic [5:0] FnMflo  = 6'b010010;

    typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

    // MULT/MULTU/DIV/DIVU all live in the 10xx code space
    function automatic logic is_mdu_ctrl(input logic [3:0] ctrl);
        return ctrl[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: shift-add multiply, restoring divide,
// one step per enabled edge; sign correction is applied combinationally.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // prod holds {partial, multiplier} for multiply and {remainder, quotient} for divide
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d, div0_q, div0_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     upper, shifted;
    logic [WIDTH-1:0]   rem_step;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed, rem_signed;

    // Done while the final iteration is being applied
    assign done_o = (cnt_q == CNT_W'(WIDTH - 1));

    // Operand latch on start, then one multiply or divide step per enabled edge
    always_comb begin
        a_neg     = is_signed_i & op_a_i[WIDTH-1];
        b_neg     = is_signed_i & op_b_i[WIDTH-1];
        mag_a     = a_neg ? -op_a_i : op_a_i;
        mag_b     = b_neg ? -op_b_i : op_b_i;
        upper     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mag_b_q} : '0);
        shifted   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        rem_step  = shifted[WIDTH-1:0] - mag_b_q;
        prod_d    = prod_q;
        mag_b_d   = mag_b_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        if (start_i) begin
            prod_d    = {{WIDTH{1'b0}}, mag_a};
            mag_b_d   = mag_b;
            cnt_d     = '0;
            is_div_d  = is_div_i;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            div0_d    = (op_b_i == '0);
        end else if (step_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!is_div_q) begin
                prod_d = {upper, prod_q[WIDTH-1:1]};
            end else if (shifted >= {1'b0, mag_b_q}) begin
                prod_d = {rem_step, prod_q[WIDTH-2:0], 1'b1};
            end else begin
                prod_d = {shifted[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign correction; divide-by-zero forces an all-ones quotient and leaves HI = op_a
    always_comb begin
        prod_signed = neg_q ? -prod_q : prod_q;
        quo_signed  = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem_signed  = rem_neg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            hi_o = rem_signed;
            lo_o = div0_q ? '1 : quo_signed;
        end else begin
            hi_o = prod_signed[2*WIDTH-1:WIDTH];
            lo_o = prod_signed[WIDTH-1:0];
        end
    end

    // Datapath state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q    <= '0;
            mag_b_q   <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            prod_q    <= prod_d;
            mag_b_q   <= mag_b_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
        end
    end

endmodule

// File: rtl/alu_ctr_mdu.sv
// EX-stage ALU control decoder with single-cycle ALU and iterative multiply/divide.
module alu_ctr_mdu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_ctrl,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d, mdu_ctrl_q, mdu_ctrl_d;
    logic             out_valid_q, out_valid_d, zero_q, zero_d;
    logic             overflow_q, overflow_d, illegal_q, illegal_d;

    logic [3:0]       dec_ctrl;
    logic [WIDTH-1:0] sum, diff, alu_res, mdu_hi, mdu_lo;
    logic             alu_ovf, slt, mdu_start, mdu_step, mdu_done;

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    // Decode alu_op/funct into the 4-bit control code
    always_comb begin
        dec_ctrl = CtrlIllegal;
        unique case (alu_op)
            AluOpAdd: dec_ctrl = CtrlAdd;
            AluOpSub: dec_ctrl = CtrlSub;
            AluOpOr:  dec_ctrl = CtrlOr;
            AluOpFunct: begin
                case (funct)
                    FnAdd, FnAddu: dec_ctrl = CtrlAdd;
                    FnSub, FnSubu: dec_ctrl = CtrlSub;
                    FnAnd:         dec_ctrl = CtrlAnd;
                    FnOr:          dec_ctrl = CtrlOr;
                    FnNor:         dec_ctrl = CtrlNor;
                    FnSlt:         dec_ctrl = CtrlSlt;
                    FnMult:        dec_ctrl = CtrlMult;
                    FnMultu:       dec_ctrl = CtrlMultu;
                    FnDiv:         dec_ctrl = CtrlDiv;
                    FnDivu:        dec_ctrl = CtrlDivu;
                    FnMfhi:        dec_ctrl = CtrlMfhi;
                    FnMflo:        dec_ctrl = CtrlMflo;
                    default:       dec_ctrl = CtrlIllegal;
                endcase
            end
            default: dec_ctrl = CtrlIllegal;
        endcase
    end

    // Single-cycle ALU; overflow only meaningful for ADD/SUB
    always_comb begin
        sum     = op_a + op_b;
        diff    = op_a - op_b;
        slt     = $signed(op_a) < $signed(op_b);
        alu_res = '0;
        alu_ovf = 1'b0;
        case (dec_ctrl)
            CtrlAdd: begin
                alu_res = sum;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            CtrlSub: begin
                alu_res = diff;
                alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            CtrlAnd:  alu_res = op_a & op_b;
            CtrlOr:   alu_res = op_a | op_b;
            CtrlNor:  alu_res = ~(op_a | op_b);
            CtrlSlt:  alu_res = {{(WIDTH-1){1'b0}}, slt};
            CtrlMfhi: alu_res = hi_q;
            CtrlMflo: alu_res = lo_q;
            default:  alu_res = '0;
        endcase
    end

    // Control FSM next state and registered outputs; flush beats completion
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        alu_ctrl_d  = alu_ctrl_q;
        mdu_ctrl_d  = mdu_ctrl_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        out_valid_d = 1'b0;
        mdu_start   = 1'b0;
        mdu_step    = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    if (is_mdu_ctrl(dec_ctrl)) begin
                        state_d    = StIter;
                        mdu_start  = 1'b1;
                        mdu_ctrl_d = dec_ctrl;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        alu_ctrl_d  = dec_ctrl;
                        overflow_d  = alu_ovf;
                        illegal_d   = (dec_ctrl == CtrlIllegal);
                        out_valid_d = 1'b1;
                    end
                end
            end
            StIter: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    mdu_step = 1'b1;
                    if (mdu_done) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!flush) begin
                    hi_d        = mdu_hi;
                    lo_d        = mdu_lo;
                    result_d    = mdu_lo;
                    zero_d      = (mdu_lo == '0);
                    alu_ctrl_d  = mdu_ctrl_q;
                    overflow_d  = 1'b0;
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            alu_ctrl_q  <= '0;
            mdu_ctrl_q  <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            alu_ctrl_q  <= alu_ctrl_d;
            mdu_ctrl_q  <= mdu_ctrl_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mdu_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (mdu_start),
        .step_i     (mdu_step),
        .is_div_i   (dec_ctrl[1]),
        .is_signed_i(!dec_ctrl[0]),
        .op_a_i     (op_a),
        .op_b_i     (op_b),
        .done_o     (mdu_done),
        .hi_o       (mdu_hi),
        .lo_o       (mdu_lo)
    );

endmodule

// File: tb/tb_alu_ctr_mdu.sv
// Scoreboard bench for alu_ctr_mdu: random and directed ops against a reference model.
module tb_alu_ctr_mdu;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid, zero, overflow, illegal, busy;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] op_a, op_b, result, hi, lo;
    logic [3:0]  alu_ctrl;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  ctrl;
        logic        ovf;
        logic        ill;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          txn = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    logic [5:0] fn_tab [14] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                6'b100101, 6'b100111, 6'b101010, 6'b011000, 6'b011001,
                                6'b011010, 6'b011011, 6'b010000, 6'b010010};

    alu_ctr_mdu #(
        .WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_op   (alu_op),
        .funct    (funct),
        .op_a     (op_a),
        .op_b     (op_b),
        .flush    (flush),
        .out_valid(out_valid),
        .result   (result),
        .alu_ctrl (alu_ctrl),
        .zero     (zero),
        .overflow (overflow),
        .illegal  (illegal),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        case (fn)
            6'b100000, 6'b100001: return 4'b0010;
            6'b100010, 6'b100011: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100111: return 4'b1100;
            6'b101010: return 4'b0111;
            6'b011000: return 4'b1000;
            6'b011001: return 4'b1001;
            6'b011010: return 4'b1010;
            6'b011011: return 4'b1011;
            6'b010000: return 4'b1101;
            6'b010010: return 4'b1110;
            default:   return 4'b1111;
        endcase
    endfunction

    // Reference model: plain 64-bit arithmetic, updates the model HI/LO
    task automatic model(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, output exp_t e);
        longint          sa, sb, s, q, r;
        longint unsigned ua, ub, p;
        logic [3:0]      c;
        c  = ref_ctrl(op, fn);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        e  = '0;
        e.ctrl = c;
        case (c)
            4'b0010: begin
                s = sa + sb;
                e.res = s[31:0];
                e.ovf = (s != longint'($signed(s[31:0])));
            end
            4'b0110: begin
                s = sa - sb;
                e.res = s[31:0];
                e.ovf = (s != longint'($signed(s[31:0])));
            end
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1100: e.res = ~(a | b);
            4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: begin
                s = sa * sb;
                m_hi = s[63:32];
                m_lo = s[31:0];
            end
            4'b1001: begin
                p = ua * ub;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            4'b1010: begin
                if (b == 0) begin
                    m_lo = '1;
                    m_hi = a;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            4'b1011: begin
                if (b == 0) begin
                    m_lo = '1;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            4'b1101: e.res = m_hi;
            4'b1110: e.res = m_lo;
            default: e.ill = 1'b1;
        endcase
        if (c[3:2] == 2'b10) e.res = m_lo;
        e.hi = m_hi;
        e.lo = m_lo;
    endtask

    // flush_at > 0: flush sampled at that edge after acceptance; < 0: issue without expectation
    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input int flush_at);
        exp_t e;
        int   guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", {63'b0, in_ready}, 64'd1);
            return;
        end
        in_valid = 1'b1;
        alu_op   = op;
        funct    = fn;
        op_a     = a;
        op_b     = b;
        if (flush_at == 0) begin
            model(op, fn, a, b, e);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (flush_at > 0) begin
            repeat (flush_at - 1) @(posedge clk);
            #1;
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
            chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
        end
    endtask

    // Called just after the accepting edge of a multi-cycle op
    task automatic check_latency(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_stall_cycles"}, 64'(n), 64'd33);
        chk({name, "_out_valid"}, {63'b0, out_valid}, 64'd1);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every out_valid pulse is matched against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid actual=1 required=0 result=%h", result);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("txn%0d.result", txn), 64'(result), 64'(e.res));
                    chk($sformatf("txn%0d.alu_ctrl", txn), 64'(alu_ctrl), 64'(e.ctrl));
                    chk($sformatf("txn%0d.zero", txn), 64'(zero), 64'(e.res == 0));
                    chk($sformatf("txn%0d.overflow", txn), 64'(overflow), 64'(e.ovf));
                    chk($sformatf("txn%0d.illegal", txn), 64'(illegal), 64'(e.ill));
                    chk($sformatf("txn%0d.hi", txn), 64'(hi), 64'(e.hi));
                    chk($sformatf("txn%0d.lo", txn), 64'(lo), 64'(e.lo));
                    txn++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] a, b;
        logic [3:0]  c;
        int          fl, guard;

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        alu_op = '0; funct = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_flags", {59'b0, out_valid, zero, overflow, illegal, busy}, 64'd0);
        chk("reset_result_ctrl", {28'b0, result, alu_ctrl}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);

        // Back-to-back single-cycle ADDs
        issue(2'b00, 6'b000000, 32'd5, 32'd7, 0);
        chk("add_result", 64'(result), 64'd12);
        chk("add_ctrl", 64'(alu_ctrl), 64'b0010);
        issue(2'b00, 6'b000000, 32'd100, 32'd23, 0);
        chk("add2_result", 64'(result), 64'd123);

        // SUB signed overflow
        issue(2'b10, 6'b100010, 32'h8000_0000, 32'd1, 0);
        chk("sub_ovf_result", 64'(result), 64'h7FFF_FFFF);
        chk("sub_ovf_flag", 64'(overflow), 64'd1);

        // MULT -3 * 7, latency, then MFLO
        issue(2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd7, 0);
        check_latency("mult");
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        issue(2'b10, 6'b010010, 32'd0, 32'd0, 0);
        chk("mflo_result", 64'(result), 64'hFFFF_FFEB);

        // Signed divide and unsigned divide by zero
        issue(2'b10, 6'b011010, 32'hFFFF_FFF9, 32'd2, 0);
        check_latency("div");
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        issue(2'b10, 6'b011011, 32'd9, 32'd0, 0);
        check_latency("divu0");
        chk("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("divu0_hi", 64'(hi), 64'd9);

        // MULTU flushed at the 10th ITER edge, then flushed in FIX
        issue(2'b10, 6'b011001, 32'd1234, 32'd5678, 10);
        chk("flush_hi", 64'(hi), 64'(m_hi));
        chk("flush_lo", 64'(lo), 64'(m_lo));
        issue(2'b10, 6'b011001, 32'd3, 32'd3, 33);
        chk("flush_fix_lo", 64'(lo), 64'(m_lo));

        // flush in IDLE suppresses acceptance
        in_valid = 1'b1; flush = 1'b1; alu_op = 2'b00; op_a = 32'd1; op_b = 32'd1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", {63'b0, busy}, 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-ITER
        issue(2'b10, 6'b011001, 32'hDEAD_BEEF, 32'h1234_5678, -1);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_flags", {59'b0, out_valid, zero, overflow, illegal, busy}, 64'd0);
        chk("rst_mid_result_ctrl", {28'b0, result, alu_ctrl}, 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        chk("rst_mid_in_ready", {63'b0, in_ready}, 64'd1);
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;

        // Illegal funct and alu_op OR
        issue(2'b10, 6'b111111, 32'h55, 32'hAA, 0);
        chk("illegal_flag", 64'(illegal), 64'd1);
        chk("illegal_ctrl", 64'(alu_ctrl), 64'b1111);
        issue(2'b11, 6'b000000, 32'hF0, 32'h0F, 0);
        chk("or_result", 64'(result), 64'hFF);
        chk("or_ctrl", 64'(alu_ctrl), 64'b0001);
        issue(2'b10, 6'b100100, 32'hF0, 32'h0F, 0);
        chk("and_zero", 64'(zero), 64'd1);

        // Randomized mix, occasional flush of multi-cycle ops
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) op = 2'b10;
            fn = fn_tab[$urandom_range(0, 13)];
            if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
            a  = rand_opnd();
            b  = rand_opnd();
            c  = ref_ctrl(op, fn);
            fl = 0;
            if (c[3:2] == 2'b10 && $urandom_range(0, 7) == 0) fl = $urandom_range(1, 33);
            issue(op, fn, a, b, fl);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        chk("drain_pending", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_ctr_mdu.md
Name: alu_ctr_mdu

Overview:
Parametrised successor to the single-cycle ALU control decoder. It decodes alu_op/funct into a 4-bit ALU control code and executes the operation behind a valid/ready handshake. Single-cycle ops return in one clock. MULT/MULTU/DIV/DIVU run iteratively and update HI/LO, which MFHI/MFLO read. It sits in the EX stage; in_ready feeds the hazard unit as the stall source.

Parameters:
WIDTH, 32, operand/result/HI/LO width; legal range ≥4.
CNT_W, $clog2(WIDTH+1), iteration counter width (localparam, derived).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  block can accept (high only in IDLE)
alu_op  in  2  main-control ALU op
funct  in  6  R-type funct field
op_a  in  WIDTH  operand A (rs)
op_b  in  WIDTH  operand B (rt/imm)
flush  in  1  abort in-flight multi-cycle op
out_valid  out  1  one-cycle pulse, result valid
result  out  WIDTH  registered result
alu_ctrl  out  4  registered control code of the completed op
zero  out  1  result == 0
overflow  out  1  signed overflow (ADD/SUB codes only)
illegal  out  1  undecodable funct
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  multi-cycle op in flight

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: all outputs 0, HI=LO=0, state IDLE, in_ready=1 in the first cycle after reset deasserts. Reset mid-operation aborts without out_valid.
- Decode, evaluated when alu_op is applied:
  - alu_op 00 → ADD 0010; alu_op 01 → SUB 0110; alu_op 11 → OR 0001.
  - alu_op 10, by funct: 100000/100001 ADD 0010; 100010/100011 SUB 0110; 100100 AND 0000; 100101 OR 0001; 100111 NOR 1100; 101010 SLT 0111; 011000 MULT 1000; 011001 MULTU 1001; 011010 DIV 1010; 011011 DIVU 1011; 010000 MFHI 1101; 010010 MFLO 1110; anything else ILLEGAL 1111.
- Accept: an op is accepted on an edge where in_valid && in_ready.
- Single-cycle ops: accepted at edge 0; result/flags/alu_ctrl registered at edge 0; out_valid high for the following cycle. Back-to-back issue is allowed every cycle.
- ILLEGAL: result 0, illegal=1, out_valid pulses, HI/LO unchanged.
- SLT: signed compare, result 1 or 0.
- Overflow: set only for ADD/SUB codes on signed overflow; the result is still written.
- State machine IDLE → ITER → FIX → IDLE.
  - IDLE→ITER on accepting a MULT/DIV-class op: latch operands; signed variants take magnitudes and record signs.
  - ITER runs exactly WIDTH edges. Multiply is shift-add, 2·WIDTH product. Divide is restoring, one quotient bit per edge.
  - FIX is one edge: apply sign correction, write HI/LO, result=LO, out_valid=1, go to IDLE.
  - Timing: accept at edge 0, out_valid after edge WIDTH+1. in_ready low and busy high from after edge 0 through edge WIDTH+1.
- Multiply: {HI,LO} = full 2·WIDTH product (signed or unsigned).
- Divide: LO=quotient, HI=remainder. Truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (signed or unsigned): LO=all ones, HI=op_a. Same latency as a normal divide.
- MFHI/MFLO: single-cycle, result=HI/LO. Only issuable in IDLE, so they never see a partial HI/LO.
- flush: in ITER or FIX, return to IDLE next edge; no out_valid, HI/LO unchanged. In IDLE, flush suppresses acceptance that edge. flush has priority over FIX.
- zero is derived from the registered result.

Decomposition:
- Shared package alu_pkg: 4-bit ALU control code constants, funct constants, alu_op constants, state enum.
- One sub-module, mdu_iter: iterative multiply/divide datapath with start/done, instantiated by alu_ctr_mdu.
- Decode and single-cycle ALU stay in the top module.

Test Plan (WIDTH=32):
1. alu_op=00, a=5, b=7 → next cycle out_valid=1, result=12, alu_ctrl=0010, zero=0; second op issued the following cycle also accepted.
2. alu_op=10, funct=100010, a=0x80000000, b=1 → result=0x7FFFFFFF, overflow=1, alu_ctrl=0110.
3. MULT a=0xFFFFFFFD, b=7 → in_ready low 33 cycles; out_valid after edge 33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MFLO → 0xFFFFFFEB.
4. DIV a=-7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=9, b=0 → LO=0xFFFFFFFF, HI=9, same 33-edge latency.
5. MULTU started, flush at 10th ITER edge → no out_valid, HI/LO keep prior values, in_ready=1 next cycle. Repeat with rst_n=0 mid-ITER → all outputs 0.
6. alu_op=10, funct=111111 → illegal=1, result=0, alu_ctrl=1111. alu_op=11, a=0xF0, b=0x0F → result=0xFF, alu_ctrl=0001.
